// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a checksummed image over UART, writes it to RAM and
// holds the CPU in reset until the image is committed and verified.
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        cpu_rst_n,
    output logic        boot_done,
    output logic        boot_err,
    output logic [15:0] words_loaded
);
    localparam logic [15:0] FULL  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] LIMIT = 17'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_MAGIC, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR} ld_state_t;

    logic [2:0]  rx_sync;
    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        byte_valid, frame_err;
    logic        rx_s, rx_prev;

    ld_state_t   ld_state, ld_state_n;
    logic [7:0]  len_lo, len_lo_n;
    logic [15:0] len, len_n, idx, idx_n, words_n;
    logic [31:0] word, word_n, addr_n;
    logic [1:0]  bcnt, bcnt_n;
    logic [7:0]  csum, csum_n, hold_byte, hold_byte_n, cur;
    logic        hold_valid, hold_valid_n, got;
    logic [15:0] new_len;

    assign rx_s    = rx_sync[1];
    assign rx_prev = rx_sync[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync  <= 3'b111;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[1:0], uart_rx};
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // All samples are taken mid-bit, counted from the synchronised start edge.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s) rx_state_n = RX_START;
            end
            RX_START: if (rx_cnt == HALF) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == FULL) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_s, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
            default: if (rx_cnt == FULL) begin
                byte_valid = rx_s;
                frame_err  = !rx_s;
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state     <= WAIT_MAGIC;
            len_lo       <= '0;
            len          <= '0;
            idx          <= '0;
            word         <= '0;
            bcnt         <= '0;
            csum         <= '0;
            hold_valid   <= 1'b0;
            hold_byte    <= '0;
            mem_addr     <= '0;
            words_loaded <= '0;
        end else begin
            ld_state     <= ld_state_n;
            len_lo       <= len_lo_n;
            len          <= len_n;
            idx          <= idx_n;
            word         <= word_n;
            bcnt         <= bcnt_n;
            csum         <= csum_n;
            hold_valid   <= hold_valid_n;
            hold_byte    <= hold_byte_n;
            mem_addr     <= addr_n;
            words_loaded <= words_n;
        end
    end

    always_comb begin
        ld_state_n   = ld_state;
        len_lo_n     = len_lo;
        len_n        = len;
        idx_n        = idx;
        word_n       = word;
        bcnt_n       = bcnt;
        csum_n       = csum;
        addr_n       = mem_addr;
        words_n      = words_loaded;
        got          = (ld_state != WRITE) && (hold_valid || byte_valid);
        cur          = hold_valid ? hold_byte : rx_shift;
        new_len      = {cur, len_lo};
        // A held byte is always consumed before a fresh one, which then takes its place.
        hold_byte_n  = byte_valid ? rx_shift : hold_byte;
        hold_valid_n = (ld_state == WRITE) ? (hold_valid || byte_valid) : (hold_valid && byte_valid);
        case (ld_state)
            WAIT_MAGIC: if (got && cur == 8'hA5) begin
                ld_state_n = LEN0;
                csum_n     = '0;
                idx_n      = '0;
            end
            LEN0: if (got) begin
                len_lo_n   = cur;
                ld_state_n = LEN1;
            end
            LEN1: if (got) begin
                len_n      = new_len;
                bcnt_n     = '0;
                ld_state_n = ({1'b0, new_len} > LIMIT) ? ERROR : (new_len == '0) ? CSUM : DATA;
            end
            DATA: if (got) begin
                word_n = {cur, word[31:8]};
                csum_n = csum + cur;
                bcnt_n = bcnt + 2'd1;
                if (bcnt == 2'd3) begin
                    addr_n     = BASE_ADDR + {14'd0, idx, 2'b00};
                    ld_state_n = WRITE;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    idx_n      = idx + 16'd1;
                    words_n    = words_loaded + 16'd1;
                    ld_state_n = (idx + 16'd1 == len) ? CSUM : DATA;
                end
                if (byte_valid && hold_valid) ld_state_n = ERROR;
            end
            CSUM: if (got) ld_state_n = (cur == csum) ? DONE : ERROR;
            default: ;
        endcase
        if (frame_err && ld_state != DONE && ld_state != ERROR) ld_state_n = ERROR;
    end

    assign mem_req   = ld_state == WRITE;
    assign mem_we    = mem_req;
    assign mem_wdata = word;
    assign boot_done = ld_state == DONE;
    assign cpu_rst_n = boot_done;
    assign boot_err  = ld_state == ERROR;
endmodule
